// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel enable, syncs, blanking, data enable and coordinates.
// A new timing is checked on offer, held in a shadow register and applied at the frame wrap.
module video_timing_gen #(
    parameter int CW       = 12,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int CE_DIV   = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_h_active,
    input  logic [CW-1:0] cfg_hs_start,
    input  logic [CW-1:0] cfg_hs_end,
    input  logic [CW-1:0] cfg_h_total,
    input  logic [CW-1:0] cfg_v_active,
    input  logic [CW-1:0] cfg_vs_start,
    input  logic [CW-1:0] cfg_vs_end,
    input  logic [CW-1:0] cfg_v_total,
    output logic          cfg_err,
    output logic          ce_pix,
    output logic          hs,
    output logic          vs,
    output logic          de,
    output logic          hblank,
    output logic          vblank,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          sof
);

    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam int DW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CE_DIV - 1);

    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    typedef struct packed {
        logic [CW-1:0] h_active;
        logic [CW-1:0] hs_start;
        logic [CW-1:0] hs_end;
        logic [CW-1:0] h_total;
        logic [CW-1:0] v_active;
        logic [CW-1:0] vs_start;
        logic [CW-1:0] vs_end;
        logic [CW-1:0] v_total;
    } timing_t;

    localparam timing_t DEFAULT_TIMING = '{
        h_active: CW'(H_ACTIVE),
        hs_start: CW'(HS_START),
        hs_end:   CW'(HS_END),
        h_total:  CW'(H_TOTAL),
        v_active: CW'(V_ACTIVE),
        vs_start: CW'(VS_START),
        vs_end:   CW'(VS_END),
        v_total:  CW'(V_TOTAL)
    };

    // One axis of a timing is usable only if the active region and sync window fit in the total.
    function automatic logic axis_ok(input logic [CW-1:0] active,
                                     input logic [CW-1:0] s_start,
                                     input logic [CW-1:0] s_end,
                                     input logic [CW-1:0] total);
        return (total >= CW'(2)) && (active >= CW'(1)) && (active < total) &&
               (s_start < s_end) && (s_end <= total);
    endfunction

    logic [DW-1:0] div_q, div_d;
    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;
    timing_t       act_q, act_d;
    timing_t       shadow_q, shadow_d;
    logic          pending_q, pending_d;
    logic          apply_q, apply_d;
    logic          cfg_ready_q, cfg_ready_d;
    logic          cfg_err_q, cfg_err_d;
    logic          ce_pix_q, ce_pix_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          de_q, de_d;
    logic          hblank_q, hblank_d;
    logic          vblank_q, vblank_d;
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          sof_q, sof_d;

    timing_t cfg_in_s;
    logic    cfg_ok_s;
    logic    offer_s;
    logic    capture_s;
    logic    ce_s;
    logic    line_end_s;
    logic    frame_end_s;
    logic    wrap_s;

    // Offer qualification and raster position events.
    always_comb begin
        cfg_in_s = '{
            h_active: cfg_h_active,
            hs_start: cfg_hs_start,
            hs_end:   cfg_hs_end,
            h_total:  cfg_h_total,
            v_active: cfg_v_active,
            vs_start: cfg_vs_start,
            vs_end:   cfg_vs_end,
            v_total:  cfg_v_total
        };
        cfg_ok_s    = axis_ok(cfg_h_active, cfg_hs_start, cfg_hs_end, cfg_h_total) &&
                      axis_ok(cfg_v_active, cfg_vs_start, cfg_vs_end, cfg_v_total);
        offer_s     = cfg_valid && cfg_ready_q;
        capture_s   = offer_s && cfg_ok_s;
        ce_s        = (div_q == DW'(0));
        line_end_s  = (h_q == (act_q.h_total - CW'(1)));
        frame_end_s = (v_q == (act_q.v_total - CW'(1)));
        wrap_s      = ce_s && line_end_s && frame_end_s;
    end

    // Next-state: divider, position, timing/shadow handshake and the registered decode.
    always_comb begin
        div_d       = div_q;
        h_d         = h_q;
        v_d         = v_q;
        act_d       = act_q;
        shadow_d    = shadow_q;
        pending_d   = pending_q;
        apply_d     = 1'b0;
        cfg_err_d   = 1'b0;
        ce_pix_d    = ce_s;
        hs_d        = hs_q;
        vs_d        = vs_q;
        de_d        = de_q;
        hblank_d    = hblank_q;
        vblank_d    = vblank_q;
        x_d         = x_q;
        y_d         = y_q;
        sof_d       = 1'b0;

        if (div_q == DIV_LAST) begin
            div_d = DW'(0);
        end else begin
            div_d = div_q + DW'(1);
        end

        if (ce_s) begin
            x_d      = h_q;
            y_d      = v_q;
            hblank_d = (h_q >= act_q.h_active);
            vblank_d = (v_q >= act_q.v_active);
            de_d     = (h_q < act_q.h_active) && (v_q < act_q.v_active);
            hs_d     = ((h_q >= act_q.hs_start) && (h_q < act_q.hs_end)) ? HS_ON : ~HS_ON;
            vs_d     = ((v_q >= act_q.vs_start) && (v_q < act_q.vs_end)) ? VS_ON : ~VS_ON;
            sof_d    = (h_q == CW'(0)) && (v_q == CW'(0));

            if (line_end_s) begin
                h_d = CW'(0);
                if (frame_end_s) begin
                    v_d = CW'(0);
                end else begin
                    v_d = v_q + CW'(1);
                end
            end else begin
                h_d = h_q + CW'(1);
            end
        end else begin
            sof_d = 1'b0;
        end

        // The in-flight frame finishes on the old timing; the shadow only lands at the wrap.
        if (wrap_s && pending_q) begin
            act_d     = shadow_q;
            pending_d = 1'b0;
            apply_d   = 1'b1;
        end else begin
            apply_d   = 1'b0;
        end

        if (capture_s) begin
            shadow_d  = cfg_in_s;
            pending_d = 1'b1;
        end else begin
            cfg_err_d = offer_s;
        end

        cfg_ready_d = ~pending_d && ~apply_d;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q       <= DW'(0);
            h_q         <= CW'(0);
            v_q         <= CW'(0);
            act_q       <= DEFAULT_TIMING;
            shadow_q    <= '0;
            pending_q   <= 1'b0;
            apply_q     <= 1'b0;
            cfg_ready_q <= 1'b0;
            cfg_err_q   <= 1'b0;
            ce_pix_q    <= 1'b0;
            hs_q        <= ~HS_ON;
            vs_q        <= ~VS_ON;
            de_q        <= 1'b0;
            hblank_q    <= 1'b0;
            vblank_q    <= 1'b0;
            x_q         <= CW'(0);
            y_q         <= CW'(0);
            sof_q       <= 1'b0;
        end else begin
            div_q       <= div_d;
            h_q         <= h_d;
            v_q         <= v_d;
            act_q       <= act_d;
            shadow_q    <= shadow_d;
            pending_q   <= pending_d;
            apply_q     <= apply_d;
            cfg_ready_q <= cfg_ready_d;
            cfg_err_q   <= cfg_err_d;
            ce_pix_q    <= ce_pix_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
            de_q        <= de_d;
            hblank_q    <= hblank_d;
            vblank_q    <= vblank_d;
            x_q         <= x_d;
            y_q         <= y_d;
            sof_q       <= sof_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign cfg_err   = cfg_err_q;
    assign ce_pix    = ce_pix_q;
    assign hs        = hs_q;
    assign vs        = vs_q;
    assign de        = de_q;
    assign hblank    = hblank_q;
    assign vblank    = vblank_q;
    assign x         = x_q;
    assign y         = y_q;
    assign sof       = sof_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: a frame-index reference model queues the expected outputs of
// every clock, and a negedge monitor pops and compares them against the DUT.
module tb_video_timing_gen;

    localparam int CW       = 12;
    localparam int H_ACTIVE = 16;
    localparam int H_FP     = 2;
    localparam int H_SYNC   = 3;
    localparam int H_BP     = 4;
    localparam int V_ACTIVE = 6;
    localparam int V_FP     = 1;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 1;
    localparam int HS_POL   = 0;
    localparam int VS_POL   = 1;
    localparam int CE_DIV   = 2;

    localparam int  FRAME_CLK = (H_ACTIVE + H_FP + H_SYNC + H_BP) * (V_ACTIVE + V_FP + V_SYNC + V_BP) * CE_DIV;
    localparam bit  HS_ON     = (HS_POL != 0);
    localparam bit  VS_ON     = (VS_POL != 0);

    typedef struct packed {
        logic [CW-1:0] ha, hss, hse, ht, va, vss, vse, vt;
    } tcfg_t;

    typedef struct packed {
        logic          rdy, err, ce, hs, vs, de, hb, vb, sof;
        logic [CW-1:0] x, y;
    } obs_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cfg_valid = 1'b0;
    logic [CW-1:0] cfg_h_active = '0, cfg_hs_start = '0, cfg_hs_end = '0, cfg_h_total = '0;
    logic [CW-1:0] cfg_v_active = '0, cfg_vs_start = '0, cfg_vs_end = '0, cfg_v_total = '0;
    logic          cfg_ready, cfg_err, ce_pix, hs, vs, de, hblank, vblank, sof;
    logic [CW-1:0] x, y;

    always #5 clk = ~clk;

    video_timing_gen #(
        .CW(CW), .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(HS_POL), .VS_POL(VS_POL), .CE_DIV(CE_DIV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_h_active(cfg_h_active), .cfg_hs_start(cfg_hs_start), .cfg_hs_end(cfg_hs_end),
        .cfg_h_total(cfg_h_total), .cfg_v_active(cfg_v_active), .cfg_vs_start(cfg_vs_start),
        .cfg_vs_end(cfg_vs_end), .cfg_v_total(cfg_v_total), .cfg_err(cfg_err),
        .ce_pix(ce_pix), .hs(hs), .vs(vs), .de(de), .hblank(hblank), .vblank(vblank),
        .x(x), .y(y), .sof(sof)
    );

    obs_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic tcfg_t default_cfg();
        tcfg_t c;
        c.ha  = CW'(H_ACTIVE);
        c.hss = CW'(H_ACTIVE + H_FP);
        c.hse = CW'(H_ACTIVE + H_FP + H_SYNC);
        c.ht  = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP);
        c.va  = CW'(V_ACTIVE);
        c.vss = CW'(V_ACTIVE + V_FP);
        c.vse = CW'(V_ACTIVE + V_FP + V_SYNC);
        c.vt  = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP);
        return c;
    endfunction

    function automatic tcfg_t make_cfg(int ha, int hss, int hse, int ht, int va, int vss, int vse, int vt);
        tcfg_t c;
        c.ha = CW'(ha); c.hss = CW'(hss); c.hse = CW'(hse); c.ht = CW'(ht);
        c.va = CW'(va); c.vss = CW'(vss); c.vse = CW'(vse); c.vt = CW'(vt);
        return c;
    endfunction

    function automatic bit cfg_legal(tcfg_t c);
        bit h_ok, v_ok;
        h_ok = (c.ht >= 2) && (c.ha >= 1) && (c.ha < c.ht) && (c.hss < c.hse) && (c.hse <= c.ht);
        v_ok = (c.vt >= 2) && (c.va >= 1) && (c.va < c.vt) && (c.vss < c.vse) && (c.vse <= c.vt);
        return h_ok && v_ok;
    endfunction

    function automatic tcfg_t rand_cfg();
        int ht, hss, vt, vss;
        tcfg_t c;
        ht  = $urandom_range(2, 30);
        hss = $urandom_range(0, ht - 1);
        vt  = $urandom_range(2, 12);
        vss = $urandom_range(0, vt - 1);
        c = make_cfg($urandom_range(1, ht - 1), hss, $urandom_range(hss + 1, ht), ht,
                     $urandom_range(1, vt - 1), vss, $urandom_range(vss + 1, vt), vt);
        case ($urandom_range(0, 7))
            0: c.hse = c.hss;
            1: c.va  = '0;
            2: c.ha  = c.ht;
            3: c.vse = c.vt + CW'(1);
            default: c.ht = c.ht;
        endcase
        return c;
    endfunction

    // Reference model: tracks a linear pixel index within the frame and derives everything from it.
    tcfg_t m_act, m_shadow, m_in;
    bit    m_pending, m_ready, m_ce, m_applied, m_err;
    int    m_clk_n, m_pix, m_px, m_py, m_ht, m_vt;
    obs_t  m_hold, m_e;

    initial begin
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_act = default_cfg(); m_pending = 0; m_ready = 0; m_clk_n = 0; m_pix = 0;
                m_e = '0;
                m_e.hs = !HS_ON;
                m_e.vs = !VS_ON;
            end else begin
                m_in = {cfg_h_active, cfg_hs_start, cfg_hs_end, cfg_h_total,
                        cfg_v_active, cfg_vs_start, cfg_vs_end, cfg_v_total};
                m_ce = (m_clk_n % CE_DIV) == 0;
                m_clk_n++;
                m_applied = 0;
                m_err = 0;
                m_e = m_hold;
                m_e.sof = 0;
                m_e.ce = m_ce;
                if (m_ce) begin
                    m_ht = m_act.ht; m_vt = m_act.vt;
                    m_px = m_pix % m_ht; m_py = m_pix / m_ht;
                    m_e.x   = CW'(m_px);
                    m_e.y   = CW'(m_py);
                    m_e.de  = (m_px < m_act.ha) && (m_py < m_act.va);
                    m_e.hb  = (m_px >= m_act.ha);
                    m_e.vb  = (m_py >= m_act.va);
                    m_e.hs  = (m_px >= m_act.hss && m_px < m_act.hse) ? HS_ON : !HS_ON;
                    m_e.vs  = (m_py >= m_act.vss && m_py < m_act.vse) ? VS_ON : !VS_ON;
                    m_e.sof = (m_pix == 0);
                    m_pix++;
                    if (m_pix == m_ht * m_vt) begin
                        m_pix = 0;
                        if (m_pending) begin
                            m_act = m_shadow; m_pending = 0; m_applied = 1;
                        end
                    end
                end
                if (m_ready && cfg_valid) begin
                    if (cfg_legal(m_in)) begin
                        m_shadow = m_in; m_pending = 1;
                    end else begin
                        m_err = 1;
                    end
                end
                m_ready = !m_pending && !m_applied;
                m_e.rdy = m_ready;
                m_e.err = m_err;
            end
            m_hold = m_e;
            exp_q.push_back(m_e);
        end
    end

    // Monitor: one comparison per clock, sampled on the falling edge.
    obs_t mon_got, mon_exp;
    initial begin
        forever begin
            @(negedge clk);
            mon_got = '{rdy: cfg_ready, err: cfg_err, ce: ce_pix, hs: hs, vs: vs, de: de,
                        hb: hblank, vb: vblank, sof: sof, x: x, y: y};
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_empty t=%0t got=%h required=an expected entry", $time, mon_got);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_got !== mon_exp) begin
                    bad++;
                    $display("FAIL outputs t=%0t got rdy%b err%b ce%b hs%b vs%b de%b hb%b vb%b sof%b x%0d y%0d required rdy%b err%b ce%b hs%b vs%b de%b hb%b vb%b sof%b x%0d y%0d",
                             $time, mon_got.rdy, mon_got.err, mon_got.ce, mon_got.hs, mon_got.vs,
                             mon_got.de, mon_got.hb, mon_got.vb, mon_got.sof, mon_got.x, mon_got.y,
                             mon_exp.rdy, mon_exp.err, mon_exp.ce, mon_exp.hs, mon_exp.vs,
                             mon_exp.de, mon_exp.hb, mon_exp.vb, mon_exp.sof, mon_exp.x, mon_exp.y);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_cfg(input tcfg_t c);
        {cfg_h_active, cfg_hs_start, cfg_hs_end, cfg_h_total,
         cfg_v_active, cfg_vs_start, cfg_vs_end, cfg_v_total} = c;
    endtask

    task automatic offer(input tcfg_t c, input int n);
        drive_cfg(c);
        cfg_valid = 1'b1;
        tick(n);
        cfg_valid = 1'b0;
    endtask

    tcfg_t small_cfg, bad_cfg, a_cfg;

    initial begin
        small_cfg = make_cfg(4, 5, 7, 10, 3, 4, 5, 6);
        bad_cfg   = make_cfg(4, 8, 8, 10, 3, 4, 5, 6);
        a_cfg     = make_cfg(8, 9, 11, 14, 3, 4, 5, 7);

        tick(3);
        rst_n = 1'b1;
        tick(2 * FRAME_CLK);

        // Reload offered mid-frame: current frame completes on defaults, then 60-pixel frames.
        tick(3 * 25 * CE_DIV + 7);
        offer(small_cfg, 1);
        tick(2 * FRAME_CLK);

        offer(bad_cfg, 1);
        tick(300);

        // Valid held across a pending apply, fields switched while still held.
        offer(a_cfg, 400);
        drive_cfg(small_cfg);
        offer(small_cfg, 400);
        tick(300);

        // Reset pulse mid-frame after a config has been applied.
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        tick(2 * FRAME_CLK + 50);

        for (int i = 0; i < 30; i++) begin
            tick($urandom_range(1, 300));
            if ($urandom_range(0, 19) == 0) begin
                rst_n = 1'b0;
                tick($urandom_range(1, 2));
                rst_n = 1'b1;
            end else begin
                offer(rand_cfg(), $urandom_range(1, 3));
            end
        end
        tick(FRAME_CLK);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
